// File: rtl/uart_rx_async.sv
// Purpose: UART receive de-framer (start, 7/8 data bits, optional parity, 1 stop) with 16x oversampling and error flags.
// Latency: stop_strobe/rx_ready rise one clk after the baud tick that takes the mid-stop decision (rx line adds SYNC_STAGES clk).
// Backpressure: none on the line; a byte completing while rx_ready=1 sets overflow and keeps the unread byte.
// Build option: define UART_RX_MAJORITY_EN for 2-of-3 majority bit decisions (default: single mid-bit sample).
module uart_rx_async #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       baud_clock,
  input  logic       rx,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       read_rx_byte,
  input  logic       clear_parity,
  input  logic       clear_framing,
  output logic [7:0] rx_byte,
  output logic       rx_ready,
  output logic       parity_err,
  output logic       framing_err,
  output logic       overflow,
  output logic       stop_strobe
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   bit_val;

  state_t      state_q, state_d;
  logic [3:0]  samp_q, samp_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  data_q, data_d;
  logic        perr_q, perr_d;
  logic        wait_q, wait_d;
  logic        load;
  logic [2:0]  last_bit;
  logic [7:0]  byte_c;

  // Metastability synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '1;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
  // Majority decisions are taken one tick after the nominal mid-bit point,
  // so the start check moves to 8 and the data/stop points wrap to 0.
  localparam logic [3:0] START_PT     = 4'd8;
  localparam logic [3:0] START_RELOAD = 4'd1;
  localparam logic [3:0] SAMPLE_PT    = 4'd0;

  logic [1:0] hist_q;

  // Keep the two previous baud-tick samples for the 2-of-3 vote.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        hist_q <= 2'b11;
    else if (baud_clock) hist_q <= {hist_q[0], rx_s};
  end

  assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
  localparam logic [3:0] START_PT     = 4'd7;
  localparam logic [3:0] START_RELOAD = 4'd0;
  localparam logic [3:0] SAMPLE_PT    = 4'd15;

  assign bit_val = rx_s;
`endif

  // 7-bit frames leave the first data bit in data_q[1]; bit7 reads as 0.
  assign last_bit = bit8 ? 3'd7 : 3'd6;
  assign byte_c   = bit8 ? data_q : {1'b0, data_q[7:1]};

  // De-framer state and counters; everything moves only on baud ticks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      samp_q  <= 4'd0;
      bit_q   <= 3'd0;
      data_q  <= 8'd0;
      perr_q  <= 1'b0;
      wait_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      samp_q  <= samp_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state: walk start/data/parity/stop at the mid-bit sample points.
  always_comb begin
    state_d = state_q;
    samp_d  = samp_q;
    bit_d   = bit_q;
    data_d  = data_q;
    perr_d  = perr_q;
    wait_d  = wait_q;
    load    = 1'b0;
    if (baud_clock) begin
      samp_d = samp_q + 4'd1;
      if (rx_s) wait_d = 1'b0;
      case (state_q)
        IDLE: begin
          samp_d = 4'd0;
          // A line still low after a bad stop bit is a break, not a new start.
          if (!rx_s && !wait_q) state_d = START;
        end
        START: begin
          if (samp_q == START_PT) begin
            if (!bit_val) begin
              state_d = DATA;
              samp_d  = START_RELOAD;
              bit_d   = 3'd0;
              data_d  = 8'd0;
              perr_d  = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end
        end
        DATA: begin
          if (samp_q == SAMPLE_PT) begin
            data_d = {bit_val, data_q[7:1]};
            bit_d  = bit_q + 3'd1;
            // >= so a mid-frame bit8 change still terminates the frame.
            if (bit_q >= last_bit) state_d = parity_en ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (samp_q == SAMPLE_PT) begin
            perr_d  = bit_val ^ odd_n_even ^ (^data_q);
            state_d = STOP;
          end
        end
        STOP: begin
          if (samp_q == SAMPLE_PT) begin
            load    = 1'b1;
            state_d = IDLE;
            if (!bit_val) wait_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Host-facing byte register and sticky flags; a set wins over a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_byte     <= 8'd0;
      rx_ready    <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      overflow    <= 1'b0;
      stop_strobe <= 1'b0;
    end else begin
      stop_strobe <= load;

      if (load) begin
        if (!rx_ready || read_rx_byte) rx_byte <= byte_c;
        rx_ready <= 1'b1;
      end else if (read_rx_byte) begin
        rx_ready <= 1'b0;
      end

      if (load && rx_ready && !read_rx_byte) overflow <= 1'b1;
      else if (read_rx_byte)                 overflow <= 1'b0;

      if (load && parity_en && perr_q) parity_err <= 1'b1;
      else if (clear_parity)           parity_err <= 1'b0;

      if (load && !bit_val)   framing_err <= 1'b1;
      else if (clear_framing) framing_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_async.sv
module tb_uart_rx_async;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       baud_clock;
  logic       rx;
  logic       bit8;
  logic       parity_en;
  logic       odd_n_even;
  logic       read_pulse;
  logic       auto_read;
  logic       read_rx_byte;
  logic       clear_parity;
  logic       clear_framing;
  logic [7:0] rx_byte;
  logic       rx_ready;
  logic       parity_err;
  logic       framing_err;
  logic       overflow;
  logic       stop_strobe;

  int nvec = 0;
  int nerr = 0;
  int strobes = 0;
  logic [7:0] log_q[$];

  always #5 clk = ~clk;

  // Host read: explicit pulse, or automatic read in the stop_strobe cycle.
  assign read_rx_byte = read_pulse | (auto_read & stop_strobe);

  uart_rx_async #(.SYNC_STAGES(2)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .baud_clock    (baud_clock),
    .rx            (rx),
    .bit8          (bit8),
    .parity_en     (parity_en),
    .odd_n_even    (odd_n_even),
    .read_rx_byte  (read_rx_byte),
    .clear_parity  (clear_parity),
    .clear_framing (clear_framing),
    .rx_byte       (rx_byte),
    .rx_ready      (rx_ready),
    .parity_err    (parity_err),
    .framing_err   (framing_err),
    .overflow      (overflow),
    .stop_strobe   (stop_strobe)
  );

  // Record every stop_strobe and the byte presented with it.
  always @(negedge clk) begin
    if (stop_strobe) begin
      strobes++;
      log_q.push_back(rx_byte);
    end
  end

  // One 16x baud tick = 4 clk; baud_clock is high across one rising edge.
  task automatic tick();
    repeat (3) @(negedge clk);
    baud_clock = 1'b1;
    @(negedge clk);
    baud_clock = 1'b0;
  endtask

  task automatic send_bit(input logic b, input int n, input int glitch_at);
    for (int i = 0; i < n; i++) begin
      rx = (i == glitch_at) ? ~b : b;
      tick();
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic b8, input logic pen,
                            input logic pbit, input logic stopv, input int g);
    send_bit(1'b0, 16, -1);
    for (int i = 0; i < (b8 ? 8 : 7); i++) send_bit(d[i], 16, g);
    if (pen) send_bit(pbit, 16, -1);
    send_bit(stopv, 16, -1);
    rx = 1'b1;
  endtask

  task automatic pulse_read();
    @(negedge clk); read_pulse = 1'b1;
    @(negedge clk); read_pulse = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    nvec++;
    if ({rx_byte, rx_ready, parity_err, framing_err, overflow, stop_strobe} !== 13'd0) begin
      nerr++;
      $display("FAIL reset_outputs got %h expected 0000",
               {rx_byte, rx_ready, parity_err, framing_err, overflow, stop_strobe});
    end
    reset_n = 1'b1;
    send_bit(1'b1, 4, -1);
  endtask

  task automatic test_8n1();
    int s0;
    bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
    s0 = strobes;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, -1);
    send_bit(1'b1, 4, -1);
    nvec++;
    if (rx_byte !== 8'hA5) begin nerr++; $display("FAIL 8n1_byte got %h expected a5", rx_byte); end
    nvec++;
    if (rx_ready !== 1'b1) begin nerr++; $display("FAIL 8n1_ready got %b expected 1", rx_ready); end
    nvec++;
    if (strobes - s0 !== 1) begin nerr++; $display("FAIL 8n1_strobes got %0d expected 1", strobes - s0); end
    nvec++;
    if ({parity_err, framing_err, overflow} !== 3'b000) begin
      nerr++; $display("FAIL 8n1_flags got %b expected 000", {parity_err, framing_err, overflow});
    end
    pulse_read();
    nvec++;
    if (rx_ready !== 1'b0) begin nerr++; $display("FAIL 8n1_read got %b expected 0", rx_ready); end
  endtask

  task automatic test_parity();
    bit8 = 1'b0; parity_en = 1'b1; odd_n_even = 1'b0;
    // 0x55 has four ones: even parity bit is 0, send 1.
    send_frame(8'h55, 1'b0, 1'b1, 1'b1, 1'b1, -1);
    send_bit(1'b1, 4, -1);
    nvec++;
    if (rx_byte !== 8'h55) begin nerr++; $display("FAIL 7e1_byte got %h expected 55", rx_byte); end
    nvec++;
    if (parity_err !== 1'b1) begin nerr++; $display("FAIL 7e1_perr got %b expected 1", parity_err); end
    nvec++;
    if (framing_err !== 1'b0) begin nerr++; $display("FAIL 7e1_ferr got %b expected 0", framing_err); end
    @(negedge clk); clear_parity = 1'b1;
    @(negedge clk); clear_parity = 1'b0;
    nvec++;
    if (parity_err !== 1'b0) begin nerr++; $display("FAIL 7e1_clear got %b expected 0", parity_err); end
    pulse_read();
  endtask

  task automatic test_framing();
    int s0;
    bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
    s0 = strobes;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    send_bit(1'b0, 40, -1);
    nvec++;
    if (framing_err !== 1'b1) begin nerr++; $display("FAIL frm_ferr got %b expected 1", framing_err); end
    nvec++;
    if (rx_byte !== 8'h3C) begin nerr++; $display("FAIL frm_byte got %h expected 3c", rx_byte); end
    nvec++;
    if (strobes - s0 !== 1) begin nerr++; $display("FAIL frm_low_line got %0d strobes expected 1", strobes - s0); end
    pulse_read();
    @(negedge clk); clear_framing = 1'b1;
    @(negedge clk); clear_framing = 1'b0;
    send_bit(1'b1, 16, -1);
    send_frame(8'h01, 1'b1, 1'b0, 1'b0, 1'b1, -1);
    send_bit(1'b1, 4, -1);
    nvec++;
    if (rx_byte !== 8'h01) begin nerr++; $display("FAIL frm_next_byte got %h expected 01", rx_byte); end
    nvec++;
    if (strobes - s0 !== 2) begin nerr++; $display("FAIL frm_next_strobes got %0d expected 2", strobes - s0); end
    nvec++;
    if (framing_err !== 1'b0) begin nerr++; $display("FAIL frm_next_ferr got %b expected 0", framing_err); end
    pulse_read();
  endtask

  task automatic test_overflow();
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b1, -1);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b1, -1);
    send_bit(1'b1, 4, -1);
    nvec++;
    if (rx_byte !== 8'h11) begin nerr++; $display("FAIL ovf_byte got %h expected 11", rx_byte); end
    nvec++;
    if ({rx_ready, overflow} !== 2'b11) begin
      nerr++; $display("FAIL ovf_flags got %b expected 11", {rx_ready, overflow});
    end
    pulse_read();
    nvec++;
    if ({rx_ready, overflow} !== 2'b00) begin
      nerr++; $display("FAIL ovf_read got %b expected 00", {rx_ready, overflow});
    end
  endtask

  task automatic test_glitch_and_reset();
    int s0;
    s0 = strobes;
    send_bit(1'b0, 4, -1);
    send_bit(1'b1, 24, -1);
    nvec++;
    if (strobes - s0 !== 0 || rx_ready !== 1'b0) begin
      nerr++; $display("FAIL false_start got %0d strobes ready %b expected 0 0", strobes - s0, rx_ready);
    end
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, -1);
    send_bit(1'b1, 4, -1);
    nvec++;
    if (rx_byte !== 8'h5A || rx_ready !== 1'b1) begin
      nerr++; $display("FAIL after_false_start got %h/%b expected 5a/1", rx_byte, rx_ready);
    end
    // Start an 8'hFF frame and reset during the data bits.
    send_bit(1'b0, 16, -1);
    send_bit(1'b1, 40, -1);
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk);
    nvec++;
    if ({rx_byte, rx_ready, parity_err, framing_err, overflow, stop_strobe} !== 13'd0) begin
      nerr++;
      $display("FAIL midframe_reset got %h expected 0000",
               {rx_byte, rx_ready, parity_err, framing_err, overflow, stop_strobe});
    end
    @(negedge clk); reset_n = 1'b1;
    s0 = strobes;
    send_bit(1'b1, 120, -1);
    nvec++;
    if (strobes - s0 !== 0 || rx_ready !== 1'b0) begin
      nerr++; $display("FAIL post_reset got %0d strobes ready %b expected 0 0", strobes - s0, rx_ready);
    end
  endtask

  task automatic test_back_to_back(input int g);
    int s0;
    int idx;
    bit8 = 1'b1; parity_en = 1'b1; odd_n_even = 1'b1;
    auto_read = 1'b1;
    s0  = strobes;
    idx = log_q.size();
    // Odd parity: 0x00 -> 1, 0xFF (eight ones) -> 1.
    send_frame(8'h00, 1'b1, 1'b1, 1'b1, 1'b1, g);
    send_frame(8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, g);
    send_bit(1'b1, 8, -1);
    auto_read = 1'b0;
    nvec++;
    if (strobes - s0 !== 2) begin nerr++; $display("FAIL b2b_strobes g%0d got %0d expected 2", g, strobes - s0); end
    nvec++;
    if (log_q.size() < idx + 2) begin
      nerr++; $display("FAIL b2b_bytes g%0d got %0d bytes expected 2", g, log_q.size() - idx);
    end else if (log_q[idx] !== 8'h00 || log_q[idx+1] !== 8'hFF) begin
      nerr++; $display("FAIL b2b_bytes g%0d got %h %h expected 00 ff", g, log_q[idx], log_q[idx+1]);
    end
    nvec++;
    if ({overflow, parity_err, framing_err, rx_ready} !== 4'b0000) begin
      nerr++; $display("FAIL b2b_flags g%0d got %b expected 0000", g, {overflow, parity_err, framing_err, rx_ready});
    end
  endtask

  initial begin
    reset_n = 1'b0; baud_clock = 1'b0; rx = 1'b1;
    bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
    read_pulse = 1'b0; auto_read = 1'b0;
    clear_parity = 1'b0; clear_framing = 1'b0;
    test_reset();
    test_8n1();
    test_parity();
    test_framing();
    test_overflow();
    test_glitch_and_reset();
    test_back_to_back(-1);
`ifdef UART_RX_MAJORITY_EN
    test_back_to_back(8);
`else
    test_back_to_back(12);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
